ram_scan_reader: RTL and testbench



---
 rtl/ram_scan_reader_if.sv | 23 ++
 rtl/ram_scan_reader.sv | 106 ++++++++++
 tb/tb_ram_scan_reader.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_scan_reader_if.sv
// RAM initiator port plus serial pixel stream of the scan reader.
// master = the reader, slave = the RAM / pixel sink side.
interface ram_scan_reader_if #(
    parameter int ADDR_W = 9
) ();
    logic              mem_load;
    logic [ADDR_W-1:0] mem_address;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              pix;
    logic              pix_valid;
    logic              pix_ready;

    modport master (
        output mem_load, mem_address, mem_wdata, pix, pix_valid,
        input  mem_rdata, pix_ready
    );

    modport slave (
        input  mem_load, mem_address, mem_wdata, pix, pix_valid,
        output mem_rdata, pix_ready
    );
endinterface

// File: rtl/ram_scan_reader.sv
// Streams RAM words 0..WORDS-1 out LSB first as pixels, or fills them with FILL.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// FETCH | capture RAM word at ptr into shreg
// SHIFT | present shreg[0]; shift on each accepted beat
// CLEAR | write FILL at ptr, one word per cycle
// DONE  | one-cycle done pulse, then back to IDLE
module ram_scan_reader #(
    parameter int          ADDR_W = 9,
    parameter int          WORDS  = 512,
    parameter logic [15:0] FILL   = 16'h0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                clear,
    output logic                busy,
    output logic                done,
    ram_scan_reader_if.master   bus
);

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, CLEAR, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx;
    logic [15:0]       shreg, shreg_nx;
    logic [3:0]        bit_cnt, bit_cnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            shreg   <= shreg_nx;
            bit_cnt <= bit_cnt_nx;
        end
    end

    assign bus.mem_address = ptr;
    assign bus.mem_wdata   = FILL;

    always_comb begin
        state_nx      = state;
        ptr_nx        = ptr;
        shreg_nx      = shreg;
        bit_cnt_nx    = bit_cnt;
        bus.mem_load  = 1'b0;
        bus.pix       = 1'b0;
        bus.pix_valid = 1'b0;
        done          = 1'b0;
        busy          = (state != IDLE);

        case (state)
            IDLE: begin
                if (start) begin
                    ptr_nx     = '0;
                    bit_cnt_nx = '0;
                    state_nx   = clear ? CLEAR : FETCH;
                end
            end
            FETCH: begin
                shreg_nx   = bus.mem_rdata;
                bit_cnt_nx = '0;
                state_nx   = SHIFT;
            end
            SHIFT: begin
                bus.pix_valid = 1'b1;
                bus.pix       = shreg[0];
                // Without a beat everything holds, so pix stays stable under backpressure.
                if (bus.pix_ready) begin
                    shreg_nx   = {1'b0, shreg[15:1]};
                    bit_cnt_nx = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) begin
                        if (ptr == LAST) begin
                            state_nx = DONE;
                        end else begin
                            ptr_nx   = ptr + 1'b1;
                            state_nx = FETCH;
                        end
                    end
                end
            end
            CLEAR: begin
                bus.mem_load = 1'b1;
                if (ptr == LAST) begin
                    state_nx = DONE;
                end else begin
                    ptr_nx = ptr + 1'b1;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_scan_reader.sv
// Bench for ram_scan_reader: three instances (WORDS=512, 4, 1), each with its own RAM,
// checked every cycle against a pass-level model of cycles, beats and writes.
module tb_ram_scan_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_s [3];
    logic        clear_s [3];
    logic        ready_s [3];
    logic        fill_en [3];
    logic [15:0] fill_val [3];
    logic        bw_en [3];
    logic [8:0]  bw_addr [3];
    logic [15:0] bw_data [3];

    logic        pix_o [3];
    logic        pv_o [3];
    logic        ml_o [3];
    logic        busy_o [3];
    logic        done_o [3];
    logic [8:0]  addr_o [3];
    logic [15:0] wd_o [3];

    int tests = 0;
    int fails = 0;

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int W = (g == 0) ? 512 : (g == 1) ? 4 : 1;
        logic [15:0] mem [512];
        ram_scan_reader_if #(.ADDR_W(9)) bus ();
        ram_scan_reader #(.ADDR_W(9), .WORDS(W), .FILL(16'h0000)) dut (
            .clk(clk), .rst(rst), .start(start_s[g]), .clear(clear_s[g]),
            .busy(busy_o[g]), .done(done_o[g]), .bus(bus)
        );
        assign bus.mem_rdata = mem[bus.mem_address];
        assign bus.pix_ready = ready_s[g];
        assign pix_o[g]  = bus.pix;
        assign pv_o[g]   = bus.pix_valid;
        assign ml_o[g]   = bus.mem_load;
        assign addr_o[g] = bus.mem_address;
        assign wd_o[g]   = bus.mem_wdata;
        always @(posedge clk) begin
            if (fill_en[g]) begin
                for (int i = 0; i < 512; i++) mem[i] <= fill_val[g];
            end else if (bw_en[g]) begin
                mem[bw_addr[g]] <= bw_data[g];
            end else if (bus.mem_load) begin
                mem[bus.mem_address] <= bus.mem_wdata;
            end
        end
    end

    function automatic logic [15:0] rd(int g, logic [8:0] a);
        case (g)
            0:       return inst[0].mem[a];
            1:       return inst[1].mem[a];
            default: return inst[2].mem[a];
        endcase
    endfunction

    function automatic int wds(int g);
        return (g == 0) ? 512 : (g == 1) ? 4 : 1;
    endfunction

    function automatic logic exp_bit(int g, int k);
        logic [15:0] w;
        w = rd(g, 9'(k / 16));
        return w[k % 16];
    endfunction

    task automatic chk(string name, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
        end
    endtask

    // Pass model: cycle index since the start edge, accepted beats, expected done cycle.
    int          m_act [3];
    int          m_clr [3];
    int          m_c [3];
    int          m_k [3];
    int          m_done_at [3];
    int          ld_n [3];
    int          done_n [3];
    int          done_c [3];
    logic [15:0] cap_w [3][4];
    bit          full_rdy [3];
    bit          armed = 1'b0;

    always @(negedge clk) begin
        int  w;
        bit  scan;
        int  end_c;
        if (armed) begin
            for (int g = 0; g < 3; g++) begin
                w    = wds(g);
                scan = (m_act[g] != 0) && (m_clr[g] == 0);
                chk($sformatf("busy[%0d]", g), int'(busy_o[g]), int'(m_act[g] != 0));
                chk($sformatf("done[%0d]", g), int'(done_o[g]),
                    int'(m_act[g] != 0 && m_c[g] == m_done_at[g]));
                chk($sformatf("mem_load[%0d]", g), int'(ml_o[g]),
                    int'(m_act[g] != 0 && m_clr[g] != 0 && m_c[g] <= w));
                if (ml_o[g]) begin
                    chk($sformatf("mem_address[%0d]", g), int'(addr_o[g]), m_c[g] - 1);
                    chk($sformatf("mem_wdata[%0d]", g), int'(wd_o[g]), 0);
                end
                if (scan && full_rdy[g])
                    chk($sformatf("pix_valid[%0d]", g), int'(pv_o[g]),
                        int'(m_c[g] <= 17 * w && (m_c[g] - 1) % 17 != 0));
                else if (!scan)
                    chk($sformatf("pix_valid_idle[%0d]", g), int'(pv_o[g]), 0);
                if (pv_o[g]) begin
                    if (m_k[g] < 16 * w)
                        chk($sformatf("pix[%0d] beat %0d", g, m_k[g]), int'(pix_o[g]), int'(exp_bit(g, m_k[g])));
                    else
                        chk($sformatf("extra_beat[%0d]", g), m_k[g], 16 * w - 1);
                end else begin
                    chk($sformatf("pix_quiet[%0d]", g), int'(pix_o[g]), 0);
                end
                if (ml_o[g]) ld_n[g]++;
                if (done_o[g]) begin
                    done_n[g]++;
                    done_c[g] = m_c[g];
                end
                // Advance the model across the coming edge.
                if (rst) begin
                    m_act[g] = 0;
                end else if (m_act[g] != 0) begin
                    if (scan && pv_o[g] && ready_s[g]) begin
                        if (m_k[g] < 64) cap_w[g][m_k[g] / 16][m_k[g] % 16] = pix_o[g];
                        m_k[g]++;
                        if (m_k[g] == 16 * w) m_done_at[g] = m_c[g] + 1;
                    end
                    end_c = m_done_at[g];
                    if (end_c != 0 && m_c[g] == end_c) m_act[g] = 0;
                    else m_c[g]++;
                end else if (start_s[g]) begin
                    m_act[g]     = 1;
                    m_clr[g]     = clear_s[g] ? 1 : 0;
                    m_c[g]       = 1;
                    m_k[g]       = 0;
                    m_done_at[g] = clear_s[g] ? w + 1 : 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(int g, logic [8:0] a, logic [15:0] d);
        bw_en[g] = 1'b1; bw_addr[g] = a; bw_data[g] = d;
        tick();
        bw_en[g] = 1'b0;
    endtask

    task automatic fill(int g, logic [15:0] v);
        fill_en[g] = 1'b1; fill_val[g] = v;
        tick();
        fill_en[g] = 1'b0;
    endtask

    // hook 1: pulse start+clear once word 2 is shifting; hook 2: reset when writing address 99.
    task automatic run(int g, bit clr, bit rnd, int hook, int maxc);
        bit fin;
        bit injected;
        fin = 1'b0;
        injected = 1'b0;
        full_rdy[g] = !rnd;
        ready_s[g]  = 1'b1;
        start_s[g]  = 1'b1;
        clear_s[g]  = clr;
        tick();
        start_s[g] = 1'b0;
        clear_s[g] = 1'b0;
        for (int i = 0; i < maxc && !fin; i++) begin
            start_s[g] = 1'b0;
            clear_s[g] = 1'b0;
            if (rnd) ready_s[g] = 1'($urandom_range(0, 1));
            if (hook == 1 && !injected && m_k[g] >= 32) begin
                start_s[g] = 1'b1;
                clear_s[g] = 1'b1;
                injected   = 1'b1;
            end
            if (hook == 2 && ml_o[g] && addr_o[g] == 9'd99) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                fin = 1'b1;
            end else begin
                tick();
                if (!busy_o[g]) fin = 1'b1;
            end
        end
        start_s[g] = 1'b0;
        clear_s[g] = 1'b0;
        ready_s[g] = 1'b1;
        chk($sformatf("pass_finished[%0d]", g), int'(fin), 1);
        if (hook == 1) chk("start_injected", int'(injected), 1);
    endtask

    initial begin
        int d0, l0, bad;
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            start_s[g] = 1'b0; clear_s[g] = 1'b0; ready_s[g] = 1'b1;
            fill_en[g] = 1'b0; fill_val[g] = '0;
            bw_en[g] = 1'b0; bw_addr[g] = '0; bw_data[g] = '0;
            full_rdy[g] = 1'b1;
        end
        tick(); tick();
        armed = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_busy", int'(busy_o[0]), 0);
        chk("reset_mem_load", int'(ml_o[0]), 0);
        chk("reset_pix_valid", int'(pv_o[1]), 0);
        chk("reset_address", int'(addr_o[2]), 0);

        // Scan of four words with the sink always ready.
        poke(1, 0, 16'h0001); poke(1, 1, 16'h8000); poke(1, 2, 16'hA5A5); poke(1, 3, 16'hFFFF);
        d0 = done_n[1];
        run(1, 0, 0, 0, 200);
        chk("scanA_done_count", done_n[1] - d0, 1);
        chk("scanA_done_cycle", done_c[1], 69);
        chk("scanA_w0", int'(cap_w[1][0]), 32'h0001);
        chk("scanA_w1", int'(cap_w[1][1]), 32'h8000);
        chk("scanA_w2", int'(cap_w[1][2]), 32'hA5A5);
        chk("scanA_w3", int'(cap_w[1][3]), 32'hFFFF);

        // Random backpressure.
        poke(1, 0, 16'h1234); poke(1, 1, 16'h0F0F); poke(1, 2, 16'h00FF); poke(1, 3, 16'hBEEF);
        d0 = done_n[1];
        run(1, 0, 1, 0, 2000);
        chk("bp_done_count", done_n[1] - d0, 1);
        chk("bp_w0", int'(cap_w[1][0]), 32'h1234);
        chk("bp_w1", int'(cap_w[1][1]), 32'h0F0F);
        chk("bp_w2", int'(cap_w[1][2]), 32'h00FF);
        chk("bp_w3", int'(cap_w[1][3]), 32'hBEEF);

        // Clear command issued while a scan is busy must be ignored.
        d0 = done_n[1];
        l0 = ld_n[1];
        run(1, 0, 0, 1, 200);
        chk("busy_start_loads", ld_n[1] - l0, 0);
        chk("busy_start_done_count", done_n[1] - d0, 1);
        chk("busy_start_done_cycle", done_c[1], 69);
        chk("busy_start_w3", int'(cap_w[1][3]), 32'hBEEF);
        chk("busy_start_ram2", int'(rd(1, 2)), 32'h00FF);

        // Single-word instance.
        poke(2, 0, 16'h0003);
        d0 = done_n[2];
        run(2, 0, 0, 0, 100);
        chk("w1_done_count", done_n[2] - d0, 1);
        chk("w1_done_cycle", done_c[2], 18);
        chk("w1_word", int'(cap_w[2][0]), 32'h0003);

        // Full clear of 512 words.
        fill(0, 16'hFFFF);
        d0 = done_n[0];
        l0 = ld_n[0];
        run(0, 1, 0, 0, 700);
        chk("clear_loads", ld_n[0] - l0, 512);
        chk("clear_done_count", done_n[0] - d0, 1);
        chk("clear_done_cycle", done_c[0], 513);
        bad = 0;
        for (int a = 0; a < 512; a++) if (rd(0, 9'(a)) != 16'h0000) bad++;
        chk("clear_nonzero_words", bad, 0);

        // Reset in the middle of a clear.
        fill(0, 16'hFFFF);
        d0 = done_n[0];
        l0 = ld_n[0];
        run(0, 1, 0, 2, 700);
        tick(); tick();
        chk("abort_done_count", done_n[0] - d0, 0);
        chk("abort_loads", ld_n[0] - l0, 100);
        chk("abort_ram99", int'(rd(0, 9'd99)), 32'h0000);
        bad = 0;
        for (int a = 100; a < 512; a++) if (rd(0, 9'(a)) != 16'hFFFF) bad++;
        chk("abort_untouched_words", bad, 0);

        // A scan after the abort restarts at address 0.
        d0 = done_n[0];
        run(0, 0, 0, 0, 9000);
        chk("rescan_done_count", done_n[0] - d0, 1);
        chk("rescan_done_cycle", done_c[0], 8705);
        chk("rescan_w0", int'(cap_w[0][0]), 32'h0000);
        chk("rescan_k", m_k[0], 8192);

        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
